// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encoding, FSM states, lane masks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11   // decoded exactly like SZ_WORD
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_WRITE    = 3'd3,
        ST_RESP     = 3'd4
    } lsu_state_e;

    // Lane masks before shifting into the addressed byte position.
    localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/lsu_lane_align.sv
// Load lane extract/extend and store lane merge into a 32-bit memory word.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
//
// Ports: size/zero_ext/offset describe the access, rdata is the memory word,
// wdata the right-justified store data; load_data is the extended load result,
// merged is rdata with only the addressed lanes replaced by wdata.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    lsu_size_e   sz;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        sz        = lsu_size_e'(size);
        shamt     = 5'd0;
        load_data = rdata;
        mask      = LANE_MASK_WORD;
        case (sz)
            SZ_BYTE: shamt = {offset, 3'b000};
            SZ_HALF: shamt = {offset[1], 4'b0000};   // halves live in lane 0 or 2 only
            default: shamt = 5'd0;
        endcase
        shifted = rdata >> shamt;
        case (sz)
            SZ_BYTE: begin
                load_data = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
                mask      = LANE_MASK_BYTE;
            end
            SZ_HALF: begin
                load_data = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
                mask      = LANE_MASK_HALF;
            end
            default: begin
                load_data = rdata;
                mask      = LANE_MASK_WORD;
            end
        endcase
        mask   = mask << shamt;
        merged = (rdata & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a pipeline and a single-port 32-bit data memory; sub-word stores use read-modify-write.
// Latency: load 2 cycles, word store 2, byte/half store 3, misaligned reject 1 (acceptance to resp_valid).
// Backpressure: req_ready only in IDLE, requester holds req_valid until accepted; resp_valid is a pulse with no backpressure.
//
// Ports: clk/reset (async, active-high); req_* request channel; resp_* one-cycle
// completion; mem_* word-indexed memory strobes with combinational mem_rdata.
// Optional feature macro LSU_MISALIGN_CHECK_EN: when defined, misaligned half/word
// accesses are rejected with resp_misaligned=1; otherwise low address bits are
// forced to natural alignment and resp_misaligned is tied low.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Word index wraps modulo MEM_WORDS (power of two), so a mask is enough.
    localparam logic [29:0] IDX_MASK = 30'(MEM_WORDS - 1);

    lsu_state_e  state;
    lsu_size_e   op_size;
    logic        op_unsigned;
    logic [1:0]  op_off;
    logic [31:0] op_wdata;

    lsu_size_e   req_sz;
    logic [1:0]  req_off;
    logic        req_mis;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_ready = (state == ST_IDLE);

    always_comb begin
        req_sz  = lsu_size_e'(req_size);
        req_off = req_addr[1:0];
        req_mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        case (req_sz)
            SZ_BYTE: req_mis = 1'b0;
            SZ_HALF: req_mis = req_addr[0];
            default: req_mis = |req_addr[1:0];
        endcase
`else
        case (req_sz)
            SZ_BYTE: req_off = req_addr[1:0];
            SZ_HALF: req_off = {req_addr[1], 1'b0};
            default: req_off = 2'b00;
        endcase
`endif
    end

    // The memory word is only valid while mem_read is high, i.e. in LOAD or
    // RMW_READ, which is exactly when these results are consumed.
    lsu_lane_align u_align (
        .size      (op_size),
        .zero_ext  (op_unsigned),
        .offset    (op_off),
        .rdata     (mem_rdata),
        .wdata     (op_wdata),
        .load_data (load_data),
        .merged    (merged_word)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_q;
    assign resp_misaligned = mis_q;
`else
    assign resp_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_size     <= SZ_WORD;
            op_unsigned <= 1'b0;
            op_off      <= 2'b00;
            op_wdata    <= 32'h0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'h0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
`ifdef LSU_MISALIGN_CHECK_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            // Strobes and the response are single-cycle unless re-armed below.
            resp_valid <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_size     <= req_sz;
                        op_unsigned <= req_unsigned;
                        op_off      <= req_off;
                        op_wdata    <= req_wdata;
                        mem_addr    <= {2'b00, req_addr[31:2] & IDX_MASK};
                        resp_rdata  <= 32'h0;
                        if (req_mis) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
                            mis_q      <= 1'b1;
`endif
                        end else if (!req_write) begin
                            state    <= ST_LOAD;
                            mem_read <= 1'b1;
                        end else if (req_sz == SZ_BYTE || req_sz == SZ_HALF) begin
                            state    <= ST_RMW_READ;
                            mem_read <= 1'b1;
                        end else begin
                            state     <= ST_WRITE;
                            mem_write <= 1'b1;
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                ST_LOAD: begin
                    resp_rdata <= load_data;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RMW_READ: begin
                    mem_wdata <= merged_word;
                    mem_write <= 1'b1;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
                    mis_q <= 1'b0;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a queue scoreboard and behavioural memory.
// Latency: n/a (testbench).
// Backpressure: driver holds each request until req_ready, then moves straight to the next.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_misaligned;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
    );

    // Behavioural memory; bench preloads go through the same write port.
    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;
    always @(posedge clk) begin
        if (pl_en)          mem[pl_idx] <= pl_dat;
        else if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
    end
    assign mem_rdata = mem_read ? mem[mem_addr[9:0]] : 32'h0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
        logic [31:0] idx;
        int          reads;
        int          writes;
        logic [31:0] wdata;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: strobe accounting and response comparison, decoupled from the driver.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                if (mem_read && mem_write) chk("strobe_exclusive", 32'(mem_read & mem_write), 32'd0);
                if (mem_read) begin
                    rd_cnt++;
                    if (sb.size() > 0) chk({sb[0].name, "_rd_addr"}, mem_addr, sb[0].idx);
                end
                if (mem_write) begin
                    wr_cnt++;
                    if (sb.size() > 0) begin
                        chk({sb[0].name, "_wr_addr"}, mem_addr, sb[0].idx);
                        chk({sb[0].name, "_wr_data"}, mem_wdata, sb[0].wdata);
                    end
                end
                if (resp_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_rdata"},  resp_rdata, e.rdata);
                        chk({e.name, "_mis"},    32'(resp_misaligned), 32'(e.mis));
                        chk({e.name, "_cycle"},  32'(cyc), 32'(e.cyc));
                        chk({e.name, "_reads"},  32'(rd_cnt), 32'(e.reads));
                        chk({e.name, "_writes"}, 32'(wr_cnt), 32'(e.writes));
                    end
                    rd_cnt = 0;
                    wr_cnt = 0;
                end
            end
        end
    end

    task automatic preload(input logic [9:0] idx, input logic [31:0] dat);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_dat = dat;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] e_rdata, input logic e_mis, input logic [31:0] e_idx,
                         input int e_reads, input int e_writes, input logic [31:0] e_wdata,
                         input int lat, input logic track);
        int budget;
        exp_t e;
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        budget       = 20;
        while (!req_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!req_ready) begin
            chk({name, "_accept_timeout"}, 32'd0, 32'd1);
        end else if (track) begin
            e.name = name;   e.rdata = e_rdata; e.mis = e_mis;
            e.cyc  = cyc + lat;   // accept edge is cyc+1; resp visible lat-1 edges later
            e.idx  = e_idx;  e.reads = e_reads; e.writes = e_writes; e.wdata = e_wdata;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int budget;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;

        preload(10'h040, 32'h80FF_1234);
        preload(10'h008, 32'h1122_3344);
        preload(10'h00C, 32'hAABB_CCDD);
        preload(10'h000, 32'h5555_5555);
        preload(10'h001, 32'h0102_0304);
        preload(10'h010, 32'h9988_7766);

        @(negedge clk);
        chk("rst_req_ready",  32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mis",        32'(resp_misaligned), 32'd0);
        chk("rst_strobes",    {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_rdata",      resp_rdata, 32'd0);
        chk("rst_mem_addr",   mem_addr, 32'd0);
        chk("rst_mem_wdata",  mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        //     name        wr  size  uns addr           wdata          e_rdata        mis  idx    rd wr e_wdata        lat
        issue("ld_b_s",    0, 2'b00, 0, 32'h0000_0103, 32'h0,         32'hFFFF_FF80, 0, 32'h40, 1, 0, 32'h0,         2, 1);
        issue("ld_b_u",    0, 2'b00, 1, 32'h0000_0103, 32'h0,         32'h0000_0080, 0, 32'h40, 1, 0, 32'h0,         2, 1);
        issue("ld_b_pos",  0, 2'b00, 0, 32'h0000_0100, 32'h0,         32'h0000_0034, 0, 32'h40, 1, 0, 32'h0,         2, 1);
        issue("ld_h_s",    0, 2'b01, 0, 32'h0000_0102, 32'h0,         32'hFFFF_80FF, 0, 32'h40, 1, 0, 32'h0,         2, 1);
        issue("ld_h_u",    0, 2'b01, 1, 32'h0000_0100, 32'h0,         32'h0000_1234, 0, 32'h40, 1, 0, 32'h0,         2, 1);
        issue("ld_w",      0, 2'b10, 0, 32'h0000_0100, 32'h0,         32'h80FF_1234, 0, 32'h40, 1, 0, 32'h0,         2, 1);
        issue("ld_rsvd",   0, 2'b11, 1, 32'h0000_0100, 32'h0,         32'h80FF_1234, 0, 32'h40, 1, 0, 32'h0,         2, 1);
        issue("st_h",      1, 2'b01, 0, 32'h0000_0022, 32'hCAFE_BEEF, 32'h0,         0, 32'h08, 1, 1, 32'hBEEF_3344, 3, 1);
        issue("st_b",      1, 2'b00, 0, 32'h0000_0031, 32'h1234_565A, 32'h0,         0, 32'h0C, 1, 1, 32'hAABB_5ADD, 3, 1);
        issue("st_w_wrap", 1, 2'b10, 0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         0, 32'h00, 0, 1, 32'hDEAD_BEEF, 2, 1);
        issue("ld_w_wrap", 0, 2'b10, 0, 32'h0000_1004, 32'h0,         32'h0102_0304, 0, 32'h01, 1, 0, 32'h0,         2, 1);
`ifdef LSU_MISALIGN_CHECK_EN
        issue("ld_w_mis",  0, 2'b10, 0, 32'h0000_0006, 32'h0,         32'h0,         1, 32'h01, 0, 0, 32'h0,         1, 1);
        issue("st_h_mis",  1, 2'b01, 0, 32'h0000_0023, 32'h0000_7777, 32'h0,         1, 32'h08, 0, 0, 32'h0,         1, 1);
`else
        issue("ld_w_algn", 0, 2'b10, 0, 32'h0000_0006, 32'h0,         32'h0102_0304, 0, 32'h01, 1, 0, 32'h0,         2, 1);
        issue("st_h_algn", 1, 2'b01, 0, 32'h0000_0023, 32'h0000_7777, 32'h0,         0, 32'h08, 1, 1, 32'h7777_3344, 3, 1);
`endif

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);

        // Reset during RMW_READ of a byte store: nothing written, no response.
        issue("rst_mid", 1, 2'b00, 0, 32'h0000_0040, 32'h0000_00AB, 32'h0, 0, 32'h10, 0, 0, 32'h0, 3, 0);
        chk("rst_mid_in_rmw", 32'(mem_read), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_write", 32'(mem_write), 32'd0);
            chk("rst_mid_no_resp", 32'(resp_valid), 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {30'd0, resp_valid, mem_write}, 32'd0);
        end

`ifdef LSU_MISALIGN_CHECK_EN
        chk("mem8_final", mem[8], 32'hBEEF_3344);
`else
        chk("mem8_final", mem[8], 32'h7777_3344);
`endif
        chk("memC_final",  mem[12], 32'hAABB_5ADD);
        chk("mem0_final",  mem[0],  32'hDEAD_BEEF);
        chk("mem10_final", mem[16], 32'h9988_7766);
        chk("mem40_final", mem[64], 32'h80FF_1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
